nand_chain_pipe: RTL and testbench



---
 rtl/nand_chain_pkg.sv | 22 ++
 rtl/nand_chain_stage.sv | 96 +++++++++
 rtl/nand_chain_pipe.sv | 112 +++++++++++
 tb/tb_nand_chain_pipe.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_chain_pkg.sv
// Shared definitions for the pipelined NAND/NOR gate chain.
// Holds mode encodings, the done-counter width and the per-bit gate.
package nand_chain_pkg;

    localparam logic MODE_NAND = 1'b0;
    localparam logic MODE_NOR  = 1'b1;

    localparam int COUNT_W = 16;

    // One bit of a chain gate: NAND in mode 0, NOR in mode 1.
    function automatic logic gate(
        input logic mode,
        input logic x,
        input logic y
    );
        if (mode == MODE_NOR) begin
            return ~(x | y);
        end
        return ~(x & y);
    endfunction

endpackage

// File: rtl/nand_chain_stage.sv
// One registered gate stage of the NAND/NOR chain.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   i_valid       : upstream item present
//   i_mode        : upstream item mode
//   i_x           : previous result r(K-1)
//   i_ops         : operand slices still carried by the item
//   i_taps        : tap slices 0..K-1 of the item
//   i_ready_dn    : downstream stage (or consumer) ready
//   o_valid       : this stage holds an item
//   o_mode        : mode of the held item
//   o_r           : r(K) of the held item
//   o_ops         : operand slices K+1..STAGES-1, rest zero
//   o_taps        : tap slices 0..K, rest zero
module nand_chain_stage
    import nand_chain_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = 3,
    parameter int K      = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_valid,
    input  logic                      i_mode,
    input  logic [WIDTH-1:0]          i_x,
    input  logic [STAGES*WIDTH-1:0]   i_ops,
    input  logic [STAGES*WIDTH-1:0]   i_taps,
    input  logic                      i_ready_dn,
    output logic                      o_valid,
    output logic                      o_mode,
    output logic [WIDTH-1:0]          o_r,
    output logic [STAGES*WIDTH-1:0]   o_ops,
    output logic [STAGES*WIDTH-1:0]   o_taps
);

    localparam int SW = STAGES * WIDTH;

    // Operand slices above K survive; slice K is consumed here.
    localparam logic [SW-1:0] OPS_KEEP =
        {SW{1'b1}} << ((K + 1) * WIDTH);
    // Tap slices below K survive; slice K is written here.
    localparam logic [SW-1:0] TAP_KEEP =
        {SW{1'b1}} >> ((STAGES - K) * WIDTH);

    logic             r_valid;
    logic             r_mode;
    logic [WIDTH-1:0] r_res;
    logic [SW-1:0]    r_ops;
    logic [SW-1:0]    r_taps;

    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_res;
    logic [SW-1:0]    w_ops;
    logic [SW-1:0]    w_taps;
    logic             w_ready;

    always_comb begin
        w_y   = i_ops[K*WIDTH +: WIDTH];
        w_res = '0;
        for (int b = 0; b < WIDTH; b++) begin
            w_res[b] = gate(i_mode, i_x[b], w_y[b]);
        end
        w_ops  = i_ops & OPS_KEEP;
        w_taps = i_taps & TAP_KEEP;
        w_taps[K*WIDTH +: WIDTH] = w_res;
    end

    // Load when empty or when the held item leaves this cycle.
    assign w_ready = ~r_valid | i_ready_dn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_mode  <= 1'b0;
            r_res   <= '0;
            r_ops   <= '0;
            r_taps  <= '0;
        end else if (w_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_mode <= i_mode;
                r_res  <= w_res;
                r_ops  <= w_ops;
                r_taps <= w_taps;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_mode  = r_mode;
    assign o_r     = r_res;
    assign o_ops   = r_ops;
    assign o_taps  = r_taps;

endmodule

// File: rtl/nand_chain_pipe.sv
// Pipelined chain of STAGES NAND/NOR gates with valid/ready on both sides.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : input handshake
//   in_a, in_ops        : first operand, per-stage second operands
//   in_mode             : 0 = NAND chain, 1 = NOR chain
//   out_valid/out_ready : output handshake
//   out_taps            : every stage result of the item
//   out_result          : last stage result
//   out_mode            : mode the item was computed with
//   done_count          : delivered items, wraps at 16 bits
module nand_chain_pipe
    import nand_chain_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [STAGES*WIDTH-1:0]  in_ops,
    input  logic                     in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [STAGES*WIDTH-1:0]  out_taps,
    output logic [WIDTH-1:0]         out_result,
    output logic                     out_mode,
    output logic [COUNT_W-1:0]       done_count
);

    localparam int SW = STAGES * WIDTH;

    // Row 0 is the input port side; row k+1 is stage k's register.
    logic [STAGES:0]            w_valid;
    logic [STAGES:0]            w_mode;
    logic [STAGES:0][WIDTH-1:0] w_r;
    logic [STAGES:0][SW-1:0]    w_taps;
    logic [STAGES-1:0][SW-1:0]  w_ops;
    // The last stage has consumed every operand slice.
    logic [SW-1:0]              w_unused_ops;

    logic [COUNT_W-1:0]         r_done_count;
    logic                       w_out_fire;

    assign w_valid[0] = in_valid;
    assign w_mode[0]  = in_mode;
    assign w_r[0]     = in_a;
    assign w_taps[0]  = '0;
    assign w_ops[0]   = in_ops;

    // ready_k = ~valid_k | ready_{k+1} unrolled: a stage can load
    // unless it and every stage after it are full and the consumer
    // stalls. Built from registered valids so no ready loop forms.
    assign in_ready = out_ready | ~(&w_valid[STAGES:1]);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic          w_rdy_dn;
        logic [SW-1:0] w_ops_nxt;

        if (k == STAGES - 1) begin : g_rdy_last
            assign w_rdy_dn = out_ready;
        end else begin : g_rdy_mid
            assign w_rdy_dn =
                out_ready | ~(&w_valid[STAGES:k+2]);
        end

        if (k < STAGES - 1) begin : g_ops_mid
            assign w_ops[k+1] = w_ops_nxt;
        end else begin : g_ops_last
            assign w_unused_ops = w_ops_nxt;
        end

        nand_chain_stage #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES),
            .K      (k)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_valid    (w_valid[k]),
            .i_mode     (w_mode[k]),
            .i_x        (w_r[k]),
            .i_ops      (w_ops[k]),
            .i_taps     (w_taps[k]),
            .i_ready_dn (w_rdy_dn),
            .o_valid    (w_valid[k+1]),
            .o_mode     (w_mode[k+1]),
            .o_r        (w_r[k+1]),
            .o_ops      (w_ops_nxt),
            .o_taps     (w_taps[k+1])
        );
    end

    assign w_out_fire = w_valid[STAGES] & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_count <= '0;
        end else if (w_out_fire) begin
            r_done_count <= r_done_count + COUNT_W'(1);
        end
    end

    assign out_valid  = w_valid[STAGES];
    assign out_mode   = w_mode[STAGES];
    assign out_result = w_r[STAGES];
    assign out_taps   = w_taps[STAGES];
    assign done_count = r_done_count;

endmodule

// File: tb/tb_nand_chain_pipe.sv
// Directed scoreboard bench for nand_chain_pipe.
// Small instance 1x3 plus wide instance 8x5 sharing one clock.
module tb_nand_chain_pipe;

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic        a_rst_n, a_in_valid, a_in_ready, a_in_mode;
    logic        a_out_valid, a_out_ready, a_out_mode;
    logic [0:0]  a_in_a, a_out_result;
    logic [2:0]  a_in_ops, a_out_taps;
    logic [15:0] a_done;

    logic        w_rst_n, w_in_valid, w_in_ready, w_in_mode;
    logic        w_out_valid, w_out_ready, w_out_mode;
    logic [7:0]  w_in_a, w_out_result;
    logic [39:0] w_in_ops, w_out_taps;
    logic [15:0] w_done;

    nand_chain_pipe #(.WIDTH(1), .STAGES(3)) u_a (
        .clk        (clk),
        .rst_n      (a_rst_n),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .in_a       (a_in_a),
        .in_ops     (a_in_ops),
        .in_mode    (a_in_mode),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_taps   (a_out_taps),
        .out_result (a_out_result),
        .out_mode   (a_out_mode),
        .done_count (a_done)
    );

    nand_chain_pipe #(.WIDTH(8), .STAGES(5)) u_w (
        .clk        (clk),
        .rst_n      (w_rst_n),
        .in_valid   (w_in_valid),
        .in_ready   (w_in_ready),
        .in_a       (w_in_a),
        .in_ops     (w_in_ops),
        .in_mode    (w_in_mode),
        .out_valid  (w_out_valid),
        .out_ready  (w_out_ready),
        .out_taps   (w_out_taps),
        .out_result (w_out_result),
        .out_mode   (w_out_mode),
        .done_count (w_done)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [3:0]  q_a[$];
    logic [40:0] q_w[$];

    bit a_fire_in, a_fire_out, a_vseen;
    bit w_fire_in, w_fire_out;

    task automatic chk(string tag, logic [63:0] obs,
                       logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h",
                    tag, obs, exp);
    endtask

    function automatic logic [2:0] model_a(
        logic m, logic a, logic [2:0] ops);
        logic       x;
        logic [2:0] t;
        x = a;
        for (int k = 0; k < 3; k++) begin
            x = m ? ~(x | ops[k]) : ~(x & ops[k]);
            t[k] = x;
        end
        return t;
    endfunction

    function automatic logic [39:0] model_w(
        logic m, logic [7:0] a, logic [39:0] ops);
        logic [7:0]  x;
        logic [7:0]  y;
        logic [39:0] t;
        x = a;
        for (int k = 0; k < 5; k++) begin
            y = ops[k*8 +: 8];
            x = m ? ~(x | y) : ~(x & y);
            t[k*8 +: 8] = x;
        end
        return t;
    endfunction

    // Called at posedge+1: sample mid-cycle, score, advance.
    task automatic tick();
        logic [3:0]  ea;
        logic [40:0] ew;
        #3;
        a_fire_in  = a_in_valid && a_in_ready;
        a_fire_out = a_out_valid && a_out_ready;
        a_vseen    = a_out_valid;
        w_fire_in  = w_in_valid && w_in_ready;
        w_fire_out = w_out_valid && w_out_ready;
        if (a_fire_out) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_out", 1, 0);
            end else begin
                ea = q_a.pop_front();
                chk("a_taps", a_out_taps, ea[2:0]);
                chk("a_result", a_out_result, ea[2]);
                chk("a_mode", a_out_mode, ea[3]);
            end
        end
        if (w_fire_out) begin
            if (q_w.size() == 0) begin
                chk("w_unexpected_out", 1, 0);
            end else begin
                ew = q_w.pop_front();
                chk("w_taps", w_out_taps, ew[39:0]);
                chk("w_result", w_out_result, ew[39:32]);
                chk("w_mode", w_out_mode, ew[40]);
            end
        end
        if (a_fire_in)
            q_a.push_back({a_in_mode,
                model_a(a_in_mode, a_in_a[0], a_in_ops)});
        if (w_fire_in)
            q_w.push_back({w_in_mode,
                model_w(w_in_mode, w_in_a, w_in_ops)});
        @(posedge clk);
        #1;
        cyc++;
        if (a_fire_in) a_in_valid = 1'b0;
        if (w_fire_in) w_in_valid = 1'b0;
    endtask

    task automatic set_a(logic m, logic a, logic [2:0] ops);
        a_in_mode  = m;
        a_in_a     = a;
        a_in_ops   = ops;
        a_in_valid = 1'b1;
    endtask

    task automatic drain(string tag);
        int i;
        i = 0;
        while ((q_a.size() != 0 || q_w.size() != 0) && i < 30) begin
            tick();
            i++;
        end
        chk(tag, q_a.size() + q_w.size(), 0);
    endtask

    task automatic reset_a();
        a_in_valid = 1'b0;
        a_rst_n    = 1'b0;
        q_a.delete();
        @(posedge clk);
        #1;
        a_rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, vcnt, first, last, acc;
        logic [3:0] bp_m;
        logic [3:0] bp_a;
        logic [2:0] bp_o [5];

        a_rst_n = 0; w_rst_n = 0;
        a_in_valid = 0; a_in_mode = 0;
        a_in_a = '0; a_in_ops = '0; a_out_ready = 1;
        w_in_valid = 0; w_in_mode = 0;
        w_in_a = '0; w_in_ops = '0; w_out_ready = 1;

        // Reset defaults
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_taps", a_out_taps, 0);
        chk("rst_out_mode", a_out_mode, 0);
        chk("rst_done", a_done, 0);
        chk("rst_w_taps", w_out_taps, 0);
        a_rst_n = 1; w_rst_n = 1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", a_in_ready, 1);

        // Single NAND item and latency
        set_a(1'b0, 1'b1, 3'b111);
        lat = 0;
        while (!a_out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("nand_latency", lat, 3);
        chk("nand_taps", a_out_taps, 3'b010);
        chk("nand_result", a_out_result, 0);
        tick();
        chk("nand_done", a_done, 1);

        // Full NOR sweep, back to back
        reset_a();
        vcnt = 0; first = -1; last = -1; acc = 0;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            set_a(1'b1, v[3], {v[0], v[1], v[2]});
            tick();
            acc += int'(a_fire_in);
            if (a_vseen) begin
                if (first < 0) first = cyc;
                last = cyc;
                vcnt++;
            end
        end
        for (int i = 0; i < 10 && q_a.size() != 0; i++) begin
            tick();
            if (a_vseen) begin
                if (first < 0) first = cyc;
                last = cyc;
                vcnt++;
            end
        end
        chk("sweep_accepts", acc, 16);
        chk("sweep_valid_cycles", vcnt, 16);
        chk("sweep_contiguous", last - first + 1, 16);
        chk("sweep_drained", q_a.size(), 0);
        chk("sweep_done", a_done, 16);

        // Backpressure: 3 fill the pipe, the rest wait
        reset_a();
        bp_m = 4'b1010;
        bp_a = 4'b1001;
        bp_o[0] = 3'b101; bp_o[1] = 3'b000; bp_o[2] = 3'b110;
        bp_o[3] = 3'b011; bp_o[4] = 3'b111;
        a_out_ready = 0;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            set_a(bp_m[i], bp_a[i], bp_o[i]);
            tick();
            acc += int'(a_fire_in);
        end
        chk("bp_accepted3", acc, 3);
        set_a(bp_m[3], bp_a[3], bp_o[3]);
        chk("bp_in_ready_low", a_in_ready, 0);
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            acc += int'(a_fire_in);
            chk("bp_stall_taps", a_out_taps, q_a[0][2:0]);
            chk("bp_stall_mode", a_out_mode, q_a[0][3]);
        end
        chk("bp_no_accept", acc, 0);
        chk("bp_out_valid", a_out_valid, 1);
        a_out_ready = 1;
        tick();
        chk("bp_resume_accept", a_fire_in, 1);
        set_a(bp_m[4], bp_a[4], bp_o[4]);
        tick();
        chk("bp_item4_accept", a_fire_in, 1);
        drain("bp_drained");
        chk("bp_done", a_done, 5);

        // Reset with two items in flight
        reset_a();
        set_a(1'b0, 1'b1, 3'b111);
        tick();
        drain("mid_first_drained");
        chk("mid_first_done", a_done, 1);
        set_a(1'b1, 1'b0, 3'b001);
        tick();
        set_a(1'b0, 1'b0, 3'b010);
        tick();
        a_rst_n = 0;
        #1;
        chk("mid_out_valid", a_out_valid, 0);
        chk("mid_out_taps", a_out_taps, 0);
        chk("mid_out_mode", a_out_mode, 0);
        chk("mid_done", a_done, 0);
        q_a.delete();
        a_in_valid = 0;
        @(posedge clk);
        #1;
        a_rst_n = 1;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            acc += int'(a_vseen);
        end
        chk("mid_never_out", acc, 0);
        chk("mid_done_after", a_done, 0);

        // Wide instance: alternating taps
        w_in_mode = 1'b0;
        w_in_a = 8'hA5;
        w_in_ops = {5{8'hFF}};
        w_in_valid = 1'b1;
        lat = 0;
        while (!w_out_valid && lat < 12) begin
            tick();
            lat++;
        end
        chk("w_latency", lat, 5);
        chk("w_alt_taps", w_out_taps, 40'h5AA55AA55A);
        chk("w_alt_result", w_out_result, 8'h5A);
        tick();
        chk("w_done1", w_done, 1);
        for (int i = 0; i < 2; i++) begin
            w_in_mode = 1'(i);
            w_in_a = 8'($urandom);
            w_in_ops = {8'($urandom), 32'($urandom)};
            w_in_valid = 1'b1;
            tick();
        end
        drain("w_drained");
        chk("w_done3", w_done, 3);

        // Stream until the counter wraps
        w_in_valid = 1'b1;
        for (int g = 0; g < 70000; g++) begin
            @(posedge clk);
            #1;
            if (w_done == 16'hFFFF) break;
        end
        chk("w_count_ffff", w_done, 16'hFFFF);
        chk("w_fire_pending", w_out_valid, 1);
        @(posedge clk);
        #1;
        chk("w_count_wrap", w_done, 16'h0000);
        w_in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
